rover_mission_sequencer: RTL

//  Top-level sequencer for one orientation pass of the rover. It requests a location fix, feeds it to

---
 rtl/rover_mission_sequencer.sv | 146 ++++++++++++++
 1 files changed

// File: rtl/rover_mission_sequencer.sv
// rtl/rover_mission_sequencer.sv - one orientation pass: locate, calculate, transmit, settle, re-locate, await orientation
module rover_mission_sequencer #(
   parameter logic [26:0] LOC_TIMEOUT   = 27'd67_500_000,
   parameter logic [26:0] SETTLE_CYCLES = 27'd40_500_000,
   parameter logic [26:0] CMD_WAIT      = 27'd3,
   parameter logic [1:0]  MAX_RETRIES   = 2'd2
) (
   input  logic        clock,
   input  logic        reset,
   input  logic        start,
   input  logic [3:0]  target_location,
   input  logic        location_valid,
   input  logic [11:0] rover_location,
   input  logic [11:0] calc_move_command,
   input  logic        calc_orient_done,
   input  logic        tx_ready,
   output logic        loc_request,
   output logic        calc_enable,
   output logic [11:0] calc_location,
   output logic [3:0]  calc_target,
   output logic        ir_send,
   output logic [11:0] ir_command,
   output logic        busy,
   output logic        done,
   output logic        error,
   output logic [3:0]  state
);

   typedef enum logic [3:0] {
      S_IDLE        = 4'h0,
      S_REQ_LOC1    = 4'h1,
      S_FEED1       = 4'h2,
      S_WAIT_CMD    = 4'h3,
      S_SEND        = 4'h4,
      S_SETTLE      = 4'h5,
      S_REQ_LOC2    = 4'h6,
      S_FEED2       = 4'h7,
      S_WAIT_ORIENT = 4'h8,
      S_DONE        = 4'h9,
      S_ERROR       = 4'hF
   } state_t;

   localparam logic [26:0] TIMER_MAX = '1;

   state_t      cur;
   logic [26:0] timer;
   logic [1:0]  retries;

   assign state       = cur;
   assign calc_target = target_location;
   assign busy        = (cur != S_IDLE) && (cur != S_DONE) && (cur != S_ERROR);
   assign error       = (cur == S_ERROR);

   always_ff @(posedge clock) begin
      if (reset) begin
         cur           <= S_IDLE;
         timer         <= '0;
         retries       <= '0;
         loc_request   <= 1'b0;
         calc_enable   <= 1'b0;
         ir_send       <= 1'b0;
         done          <= 1'b0;
         calc_location <= '0;
         ir_command    <= '0;
      end else begin
         loc_request <= 1'b0;
         calc_enable <= 1'b0;
         ir_send     <= 1'b0;
         done        <= 1'b0;
         timer       <= (timer == TIMER_MAX) ? timer : timer + 27'd1;

         case (cur)
            S_IDLE, S_ERROR: begin
               if (start) begin
                  cur         <= S_REQ_LOC1;
                  retries     <= '0;
                  loc_request <= 1'b1;
                  timer       <= '0;
               end
            end
            // loc_request is high only on the entry cycle, so it doubles as the entry marker
            S_REQ_LOC1, S_REQ_LOC2: begin
               if (!loc_request) begin
                  if (location_valid) begin
                     calc_location <= rover_location;
                     calc_enable   <= 1'b1;
                     cur           <= (cur == S_REQ_LOC1) ? S_FEED1 : S_FEED2;
                  end else if (timer == LOC_TIMEOUT - 27'd1) begin
                     if (retries == MAX_RETRIES) begin
                        cur <= S_ERROR;
                     end else begin
                        retries     <= retries + 2'd1;
                        loc_request <= 1'b1;
                        timer       <= '0;
                     end
                  end
               end
            end
            S_FEED1: begin
               timer <= '0;
               cur   <= S_WAIT_CMD;
            end
            S_FEED2: begin
               timer <= '0;
               cur   <= S_WAIT_ORIENT;
            end
            S_WAIT_CMD: begin
               if (timer == CMD_WAIT - 27'd1) begin
                  ir_command <= calc_move_command;
                  cur        <= S_SEND;
               end
            end
            S_SEND: begin
               if (tx_ready) begin
                  ir_send <= 1'b1;
                  timer   <= '0;
                  cur     <= S_SETTLE;
               end
            end
            S_SETTLE: begin
               if (timer == SETTLE_CYCLES - 27'd1) begin
                  cur         <= S_REQ_LOC2;
                  retries     <= '0;
                  loc_request <= 1'b1;
                  timer       <= '0;
               end
            end
            S_WAIT_ORIENT: begin
               if (calc_orient_done) begin
                  done <= 1'b1;
                  cur  <= S_DONE;
               end else if (timer == LOC_TIMEOUT - 27'd1) begin
                  cur <= S_ERROR;
               end
            end
            S_DONE: begin
               cur <= S_IDLE;
            end
            default: begin
               cur <= S_IDLE;
            end
         endcase
      end
   end

endmodule
